// File: rtl/tri_seg_serializer.sv
// Splits a triangular packed word (segment i is i bits wide) into N indexed beats, lowest segment first.
// Optional TRI_SER_UNIFORM_CHECK_EN adds out_uniform, flagging segments whose bits are all equal.
module tri_seg_serializer #(
    parameter int N = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N*(N+1)/2-1:0]           in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N-1:0]                   out_data,
    output logic [$clog2(N+1)-1:0]         out_idx,
    output logic                           out_last
`ifdef TRI_SER_UNIFORM_CHECK_EN
    ,
    output logic                           out_uniform
`endif
);

    localparam int TW    = N * (N + 1) / 2;
    localparam int IW    = $clog2(N + 1);
    localparam int DEPTH = 1 << IW;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   word_q, word_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [N-1:0]    data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;

    logic [IW-1:0]   nxt_idx;
    logic [N-1:0]    seg_w [DEPTH];
    logic            accept;
    logic            beat;

    // Table of every segment of the held word, indexed directly by the IW-bit index.
    for (genvar g = 0; g < DEPTH; g++) begin : g_seg
        if (g >= 1 && g <= N) begin : g_real
            localparam int BASE = g * (g - 1) / 2;
            assign seg_w[g] = N'(word_q[BASE +: g]);
        end else begin : g_pad
            assign seg_w[g] = '0;
        end
    end

`ifdef TRI_SER_UNIFORM_CHECK_EN
    logic [DEPTH-1:0] uni_w;
    logic             uni_q, uni_d;

    for (genvar g = 0; g < DEPTH; g++) begin : g_uni
        if (g >= 1 && g <= N) begin : g_real
            localparam int BASE = g * (g - 1) / 2;
            assign uni_w[g] = (&word_q[BASE +: g]) | ~(|word_q[BASE +: g]);
        end else begin : g_pad
            assign uni_w[g] = 1'b0;
        end
    end

    assign out_uniform = uni_q;
`endif

    assign in_ready = (state_q == S_IDLE) | ((state_q == S_SEND) & last_q & out_ready);
    assign accept   = in_valid & in_ready;
    assign beat     = valid_q & out_ready;
    assign nxt_idx  = idx_q + IW'(1);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
`ifdef TRI_SER_UNIFORM_CHECK_EN
        uni_d   = uni_q;
`endif
        if (accept) begin
            // Fresh word: segment 1 is just bit 0 of the incoming data.
            state_d = S_SEND;
            word_d  = in_data;
            idx_d   = IW'(1);
            data_d  = N'(in_data[0]);
            valid_d = 1'b1;
            last_d  = (N == 1);
`ifdef TRI_SER_UNIFORM_CHECK_EN
            uni_d   = 1'b1;
`endif
        end else if (state_q == S_SEND && beat) begin
            if (last_q) begin
                state_d = S_IDLE;
                idx_d   = '0;
                data_d  = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
`ifdef TRI_SER_UNIFORM_CHECK_EN
                uni_d   = 1'b0;
`endif
            end else begin
                idx_d   = nxt_idx;
                data_d  = seg_w[nxt_idx];
                last_d  = (nxt_idx == IW'(N));
`ifdef TRI_SER_UNIFORM_CHECK_EN
                uni_d   = uni_w[nxt_idx];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef TRI_SER_UNIFORM_CHECK_EN
            uni_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
`ifdef TRI_SER_UNIFORM_CHECK_EN
            uni_q   <= uni_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_tri_seg_serializer.sv
// Directed bench for tri_seg_serializer: an N=4 instance for the main scenarios plus an N=1 instance.
module tb_tri_seg_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic [2:0] out_idx;
    logic       out_last;

    logic       n1_in_valid = 1'b0;
    logic       n1_in_ready;
    logic [0:0] n1_in_data = '0;
    logic       n1_out_valid;
    logic       n1_out_ready = 1'b0;
    logic [0:0] n1_out_data;
    logic [0:0] n1_out_idx;
    logic       n1_out_last;

`ifdef TRI_SER_UNIFORM_CHECK_EN
    logic       out_uniform;
    logic       n1_out_uniform;
`endif

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    tri_seg_serializer #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
`ifdef TRI_SER_UNIFORM_CHECK_EN
        ,
        .out_uniform (out_uniform)
`endif
    );

    tri_seg_serializer #(.N(1)) dut_n1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (n1_in_valid),
        .in_ready  (n1_in_ready),
        .in_data   (n1_in_data),
        .out_valid (n1_out_valid),
        .out_ready (n1_out_ready),
        .out_data  (n1_out_data),
        .out_idx   (n1_out_idx),
        .out_last  (n1_out_last)
`ifdef TRI_SER_UNIFORM_CHECK_EN
        ,
        .out_uniform (n1_out_uniform)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total_cnt++;
        if ({out_valid, out_idx, out_data, out_last} !== 9'd0) begin
            $display("FAIL reset_outputs: got v=%b idx=%0d data=%b last=%b, want all 0", out_valid, out_idx, out_data, out_last);
        end else pass_cnt++;
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [3:0] exp_d [4] = '{4'b0001, 4'b0000, 4'b0111, 4'b0000};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 10'b0000111001;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) begin
            $display("FAIL basic_in_ready_idle: got %b want 1", in_ready);
        end else pass_cnt++;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_idx !== 3'(k + 1) || out_data !== exp_d[k] || out_last !== (k == 3)) begin
                $display("FAIL basic_beat%0d: got v=%b idx=%0d data=%b last=%b, want v=1 idx=%0d data=%b last=%b",
                         k + 1, out_valid, out_idx, out_data, out_last, k + 1, exp_d[k], (k == 3));
            end else pass_cnt++;
            total_cnt++;
            if (in_ready !== (k == 3)) begin
                $display("FAIL basic_in_ready_beat%0d: got %b want %b", k + 1, in_ready, (k == 3));
            end else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (out_valid !== 1'b0 || out_idx !== 3'd0) begin
            $display("FAIL basic_idle_after: got v=%b idx=%0d, want 0/0", out_valid, out_idx);
        end else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [3:0]  exp_d [4] = '{4'b0001, 4'b0000, 4'b0111, 4'b0000};
        logic [15:0] pat = 16'b0110_1101_0011_1001;
        int n = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 10'b0000111001;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 16 && n < 4; c++) begin
            out_ready = pat[c];
            #1;
            total_cnt++;
            if (out_valid !== 1'b1 || out_idx !== 3'(n + 1) || out_data !== exp_d[n] || out_last !== (n == 3)) begin
                $display("FAIL bp_cycle%0d: got v=%b idx=%0d data=%b last=%b, want v=1 idx=%0d data=%b last=%b",
                         c, out_valid, out_idx, out_data, out_last, n + 1, exp_d[n], (n == 3));
            end else pass_cnt++;
            if (out_ready) n++;
            tick();
        end
        total_cnt++;
        if (n !== 4 || out_valid !== 1'b0) begin
            $display("FAIL bp_beat_count: got beats=%0d v_after=%b, want 4 and 0", n, out_valid);
        end else pass_cnt++;
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_d [8] = '{4'b0001, 4'b0000, 4'b0111, 4'b0000,
                                  4'b0000, 4'b0011, 4'b0000, 4'b1111};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 10'b0000111001;
        tick();
        in_data = 10'b1111000110;
        for (int k = 0; k < 8; k++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_idx !== 3'((k % 4) + 1) || out_data !== exp_d[k] || out_last !== ((k % 4) == 3)) begin
                $display("FAIL b2b_beat%0d: got v=%b idx=%0d data=%b last=%b, want v=1 idx=%0d data=%b last=%b",
                         k + 1, out_valid, out_idx, out_data, out_last, (k % 4) + 1, exp_d[k], ((k % 4) == 3));
            end else pass_cnt++;
            if (k == 3) begin
                total_cnt++;
                if (in_ready !== 1'b1) begin
                    $display("FAIL b2b_in_ready_last: got %b want 1", in_ready);
                end else pass_cnt++;
            end
            if (k == 4) in_valid = 1'b0;
            tick();
        end
        total_cnt++;
        if (out_valid !== 1'b0) begin
            $display("FAIL b2b_idle_after: got v=%b want 0", out_valid);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid_word();
        logic [3:0] exp_d [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 10'b0000111001;
        tick();
        in_valid = 1'b0;
        tick();
        total_cnt++;
        if (out_idx !== 3'd2 || out_valid !== 1'b1) begin
            $display("FAIL rst_mid_pre: got idx=%0d v=%b, want 2/1", out_idx, out_valid);
        end else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_idx !== 3'd0 || out_data !== 4'd0 || out_last !== 1'b0) begin
            $display("FAIL rst_mid_async: got v=%b idx=%0d data=%b last=%b, want all 0", out_valid, out_idx, out_data, out_last);
        end else pass_cnt++;
        tick();
        #3 rst_n = 1'b1;
        tick();
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL rst_mid_release: got in_ready=%b v=%b, want 1/0", in_ready, out_valid);
        end else pass_cnt++;
        in_valid = 1'b1;
        in_data  = 10'h3FF;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_idx !== 3'(k + 1) || out_data !== exp_d[k] || out_last !== (k == 3)) begin
                $display("FAIL rst_mid_new_beat%0d: got v=%b idx=%0d data=%b last=%b, want v=1 idx=%0d data=%b last=%b",
                         k + 1, out_valid, out_idx, out_data, out_last, k + 1, exp_d[k], (k == 3));
            end else pass_cnt++;
            tick();
        end
    endtask

`ifdef TRI_SER_UNIFORM_CHECK_EN
    task automatic test_uniform();
        // 0101111011: seg1={1}, seg2={0,1}, seg3={1,1,1}, seg4={0,1,0,1}
        logic exp_u [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 10'b0101111011;
        total_cnt++;
        if (out_uniform !== 1'b0) begin
            $display("FAIL uniform_idle: got %b want 0", out_uniform);
        end else pass_cnt++;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (out_uniform !== exp_u[k]) begin
                $display("FAIL uniform_beat%0d: got %b want %b", k + 1, out_uniform, exp_u[k]);
            end else pass_cnt++;
            tick();
        end
    endtask
`endif

    task automatic test_n1();
        n1_out_ready = 1'b1;
        n1_in_valid  = 1'b1;
        n1_in_data   = 1'b1;
        #1;
        total_cnt++;
        if (n1_in_ready !== 1'b1) begin
            $display("FAIL n1_in_ready_idle: got %b want 1", n1_in_ready);
        end else pass_cnt++;
        tick();
        n1_in_data = 1'b0;
        #1;
        total_cnt++;
        if (n1_out_valid !== 1'b1 || n1_out_data !== 1'b1 || n1_out_idx !== 1'b1 || n1_out_last !== 1'b1 || n1_in_ready !== 1'b1) begin
            $display("FAIL n1_beat1: got v=%b data=%b idx=%b last=%b in_ready=%b, want 1 1 1 1 1",
                     n1_out_valid, n1_out_data, n1_out_idx, n1_out_last, n1_in_ready);
        end else pass_cnt++;
        tick();
        n1_in_valid = 1'b0;
        #1;
        total_cnt++;
        if (n1_out_valid !== 1'b1 || n1_out_data !== 1'b0 || n1_out_idx !== 1'b1 || n1_out_last !== 1'b1 || n1_in_ready !== 1'b1) begin
            $display("FAIL n1_beat2: got v=%b data=%b idx=%b last=%b in_ready=%b, want 1 0 1 1 1",
                     n1_out_valid, n1_out_data, n1_out_idx, n1_out_last, n1_in_ready);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (n1_out_valid !== 1'b0) begin
            $display("FAIL n1_idle_after: got v=%b want 0", n1_out_valid);
        end else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
`ifdef TRI_SER_UNIFORM_CHECK_EN
        test_uniform();
`endif
        test_n1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
